ccip_avmm_requestor_arbiter: RTL

- Shares the single CCI-P requestor AVMM port of the CCI-P/AVMM bridge among NUM_REQ AVMM masters (DMA engines, kernel ports).
- Round-robin command arbitration, with write bursts locked to one master until the last beat.
- In-order read-response routing through a requester-ID tracker FIFO.

---
 rtl/ccip_avmm_requestor_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ccip_avmm_requestor_arbiter.sv
// ccip_avmm_requestor_arbiter: shares one CCI-P requestor AVMM port among NUM_REQ masters.
// Define CCIP_AVMM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module ccip_avmm_requestor_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 48,
    parameter int BURST_WIDTH    = 3,
    parameter int RD_TRACK_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_avmm_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_avmm_writedata,
    input  logic [NUM_REQ*BURST_WIDTH-1:0] req_avmm_burstcount,
    input  logic [NUM_REQ-1:0]             req_avmm_read,
    input  logic [NUM_REQ-1:0]             req_avmm_write,
    output logic [NUM_REQ-1:0]             req_avmm_waitrequest,
    output logic [DATA_WIDTH-1:0]          req_avmm_readdata,
    output logic [NUM_REQ-1:0]             req_avmm_readdatavalid,
    output logic [ADDR_WIDTH-1:0]          host_avmm_address,
    output logic [DATA_WIDTH-1:0]          host_avmm_writedata,
    output logic [BURST_WIDTH-1:0]         host_avmm_burstcount,
    output logic                           host_avmm_read,
    output logic                           host_avmm_write,
    input  logic                           host_avmm_waitrequest,
    input  logic [DATA_WIDTH-1:0]          host_avmm_readdata,
    input  logic                           host_avmm_readdatavalid,
    output logic                           rsp_err
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int PW = RD_TRACK_DEPTH > 1 ? $clog2(RD_TRACK_DEPTH) : 1;
    localparam logic [BURST_WIDTH-1:0] bc_one = BURST_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CMD, WR_BURST} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          grant_q, grant_d, base, win;
    logic [BURST_WIDTH-1:0] remaining_q, remaining_d, beat_q, bc_eff, head_bc;
    logic [IW-1:0]          fifo_id [RD_TRACK_DEPTH];
    logic [BURST_WIDTH-1:0] fifo_bc [RD_TRACK_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [PW:0]            count_q;
    logic [IW-1:0]          head_id;
    logic [NUM_REQ-1:0]     elig;
    logic                   win_ok, full, empty, push, pop, rsp_hit, done, g_rd, g_wr;

    assign host_avmm_address    = req_avmm_address[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    assign host_avmm_writedata  = req_avmm_writedata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign host_avmm_burstcount = req_avmm_burstcount[int'(grant_q)*BURST_WIDTH +: BURST_WIDTH];
    assign g_rd   = req_avmm_read[grant_q];
    assign g_wr   = req_avmm_write[grant_q];
    assign bc_eff = (host_avmm_burstcount == '0) ? bc_one : host_avmm_burstcount;

    assign full  = count_q == (PW+1)'(RD_TRACK_DEPTH);
    assign empty = count_q == '0;
    assign elig  = req_avmm_write | (req_avmm_read & {NUM_REQ{~full}});

`ifdef CCIP_AVMM_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IW-1:0] rr_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr_q <= '0;
        else if (done)
            rr_q <= IW'((int'(grant_q) + 1) % NUM_REQ);
    end
    assign base = rr_q;
`endif

    // first eligible master at or after base, wrapping
    always_comb begin
        win_ok = 1'b0;
        win = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_ok && elig[(int'(base) + k) % NUM_REQ]) begin
                win_ok = 1'b1;
                win = IW'((int'(base) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        remaining_d = remaining_q;
        done = 1'b0;
        push = 1'b0;
        host_avmm_read = 1'b0;
        host_avmm_write = 1'b0;
        req_avmm_waitrequest = '1;
        case (state_q)
            IDLE: begin
                if (win_ok) begin
                    grant_d = win;
                    state_d = CMD;
                end
            end
            CMD: begin
                // read+write together is treated as a write
                host_avmm_write = g_wr;
                host_avmm_read = g_rd & ~g_wr;
                req_avmm_waitrequest[grant_q] = host_avmm_waitrequest;
                if ((g_rd | g_wr) && !host_avmm_waitrequest) begin
                    if (g_wr && bc_eff != bc_one) begin
                        remaining_d = bc_eff - bc_one;
                        state_d = WR_BURST;
                    end else begin
                        push = ~g_wr;
                        done = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WR_BURST: begin
                host_avmm_write = g_wr;
                req_avmm_waitrequest[grant_q] = host_avmm_waitrequest;
                if (g_wr && !host_avmm_waitrequest) begin
                    remaining_d = remaining_q - bc_one;
                    if (remaining_q == bc_one) begin
                        done = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign head_id = fifo_id[rd_ptr_q];
    assign head_bc = fifo_bc[rd_ptr_q];
    assign rsp_hit = host_avmm_readdatavalid & ~empty;
    assign pop     = rsp_hit && (beat_q + bc_one == head_bc);
    assign req_avmm_readdata = host_avmm_readdata;

    always_comb begin
        req_avmm_readdatavalid = '0;
        req_avmm_readdatavalid[head_id] = rsp_hit;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id[wr_ptr_q] <= grant_q;
            fifo_bc[wr_ptr_q] <= bc_eff;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            remaining_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            beat_q <= '0;
            rsp_err <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            remaining_q <= remaining_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
            if (rsp_hit)
                beat_q <= pop ? '0 : beat_q + bc_one;
            if (host_avmm_readdatavalid && empty)
                rsp_err <= 1'b1;
        end
    end
endmodule
